// File: rtl/addr8s_pkg.sv
// Shared types and defaults for the 8-bit signed adder checker/accumulator.
//   state_t  : frame FSM states (ACCUM collects beats, HOLD presents a frame)
//   *_DEF    : default parameter values for addr8s_check_acc
//   cnt_w()  : width needed to hold a count of 0..n inclusive
package addr8s_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int FRAME_LEN_DEF = 8;
  localparam int ACC_W_DEF     = 12;
  localparam int ERR_W_DEF     = 8;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/addr8s_ref_sum.sv
// Golden reference for an 8-bit signed adder.
//   a, b    : signed operands as presented to the adder under test
//   sum     : 9-bit result produced by the adder under test
//   golden  : exact 9-bit sum of a and b (cannot overflow)
//   mismatch: high when sum differs from golden
module addr8s_ref_sum (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [8:0] sum,
  output logic [8:0] golden,
  output logic       mismatch
);

  assign golden   = {a[7], a} + {b[7], b};
  assign mismatch = (sum != golden);

endmodule

// File: rtl/addr8s_check_acc.sv
// Checks each beat of an 8-bit signed adder against a golden sum and
// accumulates the golden sums over a frame of FRAME_LEN beats.
//   clk, rst             : clock, async active-high reset
//   clr                  : synchronous frame abort (err_total kept)
//   in_valid/in_ready    : beat handshake (ready only while accumulating)
//   in_a, in_b, in_sum   : operands and adder result under check
//   out_valid/out_ready  : frame result handshake
//   out_acc              : signed sum of golden beat sums in the frame
//   out_fault_cnt/_fault : mismatching beats in the frame / any mismatch
//   err_total            : lifetime mismatch count, saturating
module addr8s_check_acc
  import addr8s_pkg::*;
#(
  parameter  int FRAME_LEN = FRAME_LEN_DEF,
  parameter  int ACC_W     = ACC_W_DEF,
  parameter  int ERR_W     = ERR_W_DEF,
  localparam int FCW       = cnt_w(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [8:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [FCW-1:0]   out_fault_cnt,
  output logic             out_fault,
  output logic [ERR_W-1:0] err_total
);

  state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q;
  logic [FCW-1:0]   beat_q;
  logic [FCW-1:0]   fault_q;
  logic [8:0]       golden;
  logic             mismatch;
  logic             accept;
  logic             last_beat;
  logic             pop;

  addr8s_ref_sum u_ref (
    .a        (in_a),
    .b        (in_b),
    .sum      (in_sum),
    .golden   (golden),
    .mismatch (mismatch)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign last_beat = (beat_q == FCW'(FRAME_LEN - 1));

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && last_beat) state_d = HOLD;
        HOLD:    if (pop) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Frame counters: cleared by clr or when a held frame is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      beat_q  <= '0;
      fault_q <= '0;
    end else if (clr || pop) begin
      acc_q   <= '0;
      beat_q  <= '0;
      fault_q <= '0;
    end else if (accept) begin
      // Accumulate the golden sum so a faulty adder cannot corrupt the total.
      acc_q  <= acc_q + {{(ACC_W-9){golden[8]}}, golden};
      beat_q <= beat_q + 1'b1;
      if (mismatch) fault_q <= fault_q + 1'b1;
    end
  end

  // Lifetime counter survives clr; a beat discarded by clr is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_total <= '0;
    else if (accept && !clr && mismatch && (err_total != {ERR_W{1'b1}}))
      err_total <= err_total + 1'b1;
  end

  assign out_acc       = acc_q;
  assign out_fault_cnt = fault_q;
  assign out_fault     = (fault_q != '0);

endmodule

// File: doc/addr8s_check_acc.md
ADDR8S_CHECK_ACC -- requirements
Module: addr8s_check_acc

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, meaning beats accumulated per frame (legal range 2..64).
REQ-002 The block SHALL have parameter ACC_W, default 12, meaning accumulator width; legality rule ACC_W >= 9 + clog2(FRAME_LEN).
REQ-003 The block SHALL have parameter ERR_W, default 8, meaning width of the lifetime fault counter.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clr  input  1  synchronous frame abort and clear.
REQ-007 in_valid  input  1  upstream beat valid.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_a  input  8  signed operand A[7:0] as presented to the 8-bit signed adder.
REQ-010 in_b  input  8  signed operand B[7:0] as presented to the adder.
REQ-011 in_sum  input  9  adder result O[8:0] under check, two's complement.
REQ-012 out_valid  output  1  frame result available.
REQ-013 out_ready  input  1  downstream accepts frame result.
REQ-014 out_acc  output  ACC_W  signed frame sum of golden beat sums.
REQ-015 out_fault_cnt  output  clog2(FRAME_LEN+1)  mismatching beats in the frame.
REQ-016 out_fault  output  1  high iff out_fault_cnt != 0.
REQ-017 err_total  output  ERR_W  lifetime mismatch count, saturating.

Function
REQ-018 Golden sum SHALL be sext9(in_a) + sext9(in_b), exact, no overflow possible.
REQ-019 A beat SHALL be a mismatch iff in_sum != golden sum.
REQ-020 FSM states SHALL be ACCUM and HOLD; reset state ACCUM.
REQ-021 in_ready SHALL be 1 in ACCUM and 0 in HOLD, combinationally from state only.
REQ-022 Handshake SHALL be in_valid && in_ready; in HOLD, in_valid and beat data SHALL be ignored.
REQ-023 Each accepted beat SHALL add the sign-extended golden sum (never in_sum) to the accumulator and increment beat count.
REQ-024 Each accepted mismatch SHALL increment the frame fault count and err_total.
REQ-025 err_total SHALL saturate at 2^ERR_W-1; only rst clears it.
REQ-026 Accepting beat number FRAME_LEN SHALL move ACCUM->HOLD; out_valid SHALL be 1 the next cycle (latency 1 after last beat) with final values including that beat.
REQ-027 In HOLD, out_acc, out_fault_cnt and out_fault SHALL be stable while out_valid && !out_ready.
REQ-028 out_valid && out_ready SHALL move HOLD->ACCUM, clearing accumulator, beat count and frame fault count; first new beat accepted the following cycle.
REQ-029 clr SHALL have priority over any handshake: in either state, next state ACCUM, accumulator/beat/frame-fault counts cleared, out_valid 0; err_total unaffected, the beat on the clr cycle discarded and not counted.
REQ-030 out_acc/out_fault_cnt in ACCUM SHALL show running values (don't-care to consumers while out_valid=0).

Reset
REQ-031 rst SHALL asynchronously force state ACCUM, out_valid=0, in_ready=1, out_acc=0, out_fault_cnt=0, out_fault=0, err_total=0, beat count 0.
REQ-032 rst mid-frame or in HOLD SHALL discard the partial or pending frame without emitting it.

Structure
REQ-033 Package addr8s_pkg SHALL hold the FSM state enum, FRAME_LEN/ACC_W/ERR_W defaults and the count-width function.
REQ-034 Sub-module addr8s_ref_sum SHALL compute golden 9-bit sum and mismatch combinationally; the FSM/counters live in addr8s_check_acc.

Verification
REQ-035 rst pulse mid-frame -> all outputs at REQ-031 values immediately, before next clk edge.
REQ-036 8 beats a=127,b=127,sum=9'h0FE -> out_acc=2032, out_fault_cnt=0, out_valid one cycle after 8th beat.
REQ-037 8 beats a=-128,b=-128,sum=9'h100 -> out_acc=12'h800 (-2048), out_fault=0.
REQ-038 one beat a=1,b=2,sum=9'h004 among 7 correct zero beats -> out_acc=3, out_fault_cnt=1, err_total+1.
REQ-039 out_ready low 5 cycles in HOLD with in_valid high -> outputs stable, in_ready=0, no beats counted; then out_ready high -> ACCUM, next beat starts fresh frame.
REQ-040 clr after 3 beats then 8 beats of a=1,b=1 -> out_acc=16; with ERR_W=2, 5 mismatches -> err_total=3.
